vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters: the VGA scan-out fetch (driven by the sync generator's counters) and a host write port.
- Display fetches win during active video; host writes win during blanking.
- A starvation guard forces host progress even if the display never idles.
- Sits between the vga_sync timing logic and the board's video memory on the Papilio.

Parameters:
- ADDR_W, 14, video RAM address width
- DATA_W, 8, video RAM data width
- FIFO_DEPTH, 4, host write FIFO entries (power of 2, >=2)
- STARVE_MAX, 16, consecutive denied cycles with a non-empty FIFO before a forced host write (>=1)

Ports:
- clkin  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous reset, active-low
- blank  in  1  1 = horizontal or vertical blanking, from the sync generator
- disp_req  in  1  display read request, one word per asserted cycle
- disp_addr  in  ADDR_W  display read address
- disp_data  out  DATA_W  read data (mem_rdata passthrough)
- disp_valid  out  1  disp_data valid this cycle
- disp_miss  out  1  pulse: display request was dropped
- host_wr_valid  in  1  host write offered
- host_wr_ready  out  1  = FIFO not full
- host_addr  in  ADDR_W  host write address
- host_wdata  in  DATA_W  host write data
- fifo_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after an mem_en && !mem_we cycle

Behaviour:
- Reset (rstn=0 at an edge):
  - mem_en, mem_we, mem_addr, mem_wdata, disp_valid, disp_miss, fifo_count and the starve counter are all cleared to 0.
  - FIFO is emptied.
  - host_wr_ready is forced to 0 while rstn=0, then is 1 from the first cycle after release.
  - Reset mid-operation discards all FIFO contents and any in-flight read; no disp_valid follows.
- FIFO:
  - A push occurs when host_wr_valid && host_wr_ready at an edge.
  - Simultaneous push and pop leaves the count unchanged.
  - A pushed entry is eligible for grant starting the cycle after the push; there is no fall-through.
- Grant decision each cycle (one grant at most):
  - G1 forced: FIFO non-empty and starve == STARVE_MAX -> host write.
  - G2 blank=1: FIFO non-empty -> host write; else disp_req -> display read.
  - G3 blank=0: disp_req -> display read; else FIFO non-empty -> host write.
  - Otherwise idle.
- Grant effects:
  - Host write grant: pops the FIFO head. After the edge, mem_en=1, mem_we=1, and mem_addr/mem_wdata = head entry.
  - Display grant: after the edge, mem_en=1, mem_we=0, mem_addr = disp_addr.
  - Idle: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their previous values.
- Display timing:
  - disp_req sampled in cycle c -> mem_en in cycle c+1 -> disp_valid=1 in cycle c+2, with disp_data = mem_rdata.
  - Fixed latency of 2 cycles, fully pipelined: back-to-back requests give back-to-back disp_valid.
- disp_miss:
  - Any cycle with disp_req=1 that does not receive the grant (G1, or G2 with a non-empty FIFO) produces disp_miss=1 in cycle c+2, i.e. the slot where disp_valid would have been.
  - disp_valid and disp_miss are never both 1.
- Starve counter:
  - Cleared on any host grant or when the FIFO is empty.
  - Otherwise increments each cycle the FIFO is non-empty and not granted.
  - Saturates at STARVE_MAX.
- Writes and reads to the same address are not forwarded; order is strictly grant order.

Test Plan:
- Active-video streaming: blank=0, disp_req high 8 cycles at addresses 0..7, RAM preloaded mem[i]=i+0x10 -> disp_valid high in cycles 2..9 with data 0x10..0x17, no disp_miss.
- Blanking priority: push 2 writes (0x100<-0xAA, 0x101<-0xBB), then blank=1 with disp_req=1 -> mem_we pulses for 0x100 and 0x101 first, 2 disp_miss pulses, then reads resume; reading 0x100 later returns 0xAA.
- Starvation: STARVE_MAX=4, blank=0, disp_req held high, push 1 write -> after 4 denied cycles exactly one forced write, one disp_miss 2 cycles later, starve counter back to 0.
- Backpressure: blank=0, disp_req high, push 5 writes back-to-back -> host_wr_ready=0 after the 4th push, fifo_count=4, 5th write accepted only after the forced pop.
- Reset mid-operation: FIFO at 3 entries and read in flight, rstn=0 for 1 cycle -> all outputs 0, no disp_valid follows, fifo_count=0, host_wr_ready=1 the cycle after release.
- Push into an empty FIFO with disp_req=0 and blank=0 -> mem_we=1 exactly 2 cycles after the push edge, never 1.

Source files
------------

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port video RAM between VGA scan-out reads and a FIFO-buffered
// host write port; display wins in active video, host wins in blanking, starvation forces host.
module vram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 16
) (
    input  logic                          clkin,
    input  logic                          rstn,
    input  logic                          blank,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic [DATA_W-1:0]             disp_data,
    output logic                          disp_valid,
    output logic                          disp_miss,
    input  logic                          host_wr_valid,
    output logic                          host_wr_ready,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]             host_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] fifoAddr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifoData_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              memEn_q, memEn_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              rdPend_q, missPend_q;
    logic              dispValid_q, dispMiss_q;

    logic push, fifoNonEmpty, forced, hostGrant, dispGrant;

    assign host_wr_ready = rstn && (count_q != CNT_W'(FIFO_DEPTH));
    assign push          = host_wr_valid && host_wr_ready;
    assign fifoNonEmpty  = (count_q != '0);
    assign forced        = fifoNonEmpty && (starve_q == STV_W'(STARVE_MAX));
    assign hostGrant     = fifoNonEmpty && (forced || blank || !disp_req);
    assign dispGrant     = disp_req && !hostGrant;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        memEn_d    = 1'b0;
        memWe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;

        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (hostGrant) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({push, hostGrant})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Starvation only accrues while something is waiting and is refused
        if (hostGrant || !fifoNonEmpty) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end

        if (hostGrant) begin
            memEn_d    = 1'b1;
            memWe_d    = 1'b1;
            memAddr_d  = fifoAddr_q[rdPtr_q];
            memWdata_d = fifoData_q[rdPtr_q];
        end else if (dispGrant) begin
            memEn_d   = 1'b1;
            memAddr_d = disp_addr;
        end
    end

    always_ff @(posedge clkin) begin
        if (push) begin
            fifoAddr_q[wrPtr_q] <= host_addr;
            fifoData_q[wrPtr_q] <= host_wdata;
        end
    end

    // Read status travels alongside the RAM's one-cycle latency so valid/miss land in the same slot
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            memEn_q     <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            rdPend_q    <= 1'b0;
            missPend_q  <= 1'b0;
            dispValid_q <= 1'b0;
            dispMiss_q  <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            memEn_q     <= memEn_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            rdPend_q    <= dispGrant;
            missPend_q  <= disp_req && !dispGrant;
            dispValid_q <= rdPend_q;
            dispMiss_q  <= missPend_q;
        end
    end

    assign disp_data  = mem_rdata;
    assign disp_valid = dispValid_q;
    assign disp_miss  = dispMiss_q;
    assign fifo_count = count_q;
    assign mem_en     = memEn_q;
    assign mem_we     = memWe_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: a queue-based arbitration model plus a behavioural RAM
// predict every memory command, display result and FIFO status cycle by cycle.
module tb_vram_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 3;
    localparam int NUM_CYCLES = 4000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clkin = 1'b0;
    logic              rstn;
    logic              blank;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              disp_miss;
    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clkin = ~clkin;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clkin(clkin), .rstn(rstn), .blank(blank),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_valid(disp_valid), .disp_miss(disp_miss),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_addr(host_addr), .host_wdata(host_wdata), .fifo_count(fifo_count),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Board RAM: single port, synchronous read
    logic [DATA_W-1:0] ram [1 << ADDR_W];
    always @(posedge clkin) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model: the FIFO is a queue and memory contents are tracked in grant order
    entry_t            fifoQ[$];
    entry_t            headEntry;
    logic [DATA_W-1:0] modelMem [1 << ADDR_W];
    int                starve = 0;
    logic              expEn = 0, expWe = 0, expValid = 0, expMiss = 0;
    logic [ADDR_W-1:0] expAddr = '0;
    logic [DATA_W-1:0] expWdata = '0, expData = '0;
    logic              p1Valid = 0, p1Miss = 0;
    logic [DATA_W-1:0] p1Data = '0;
    logic              hasWork, hostWins, dispWins, pushOk;

    always @(posedge clkin) begin
        if (!rstn) begin
            fifoQ.delete();
            starve   = 0;
            expEn    = 0;
            expWe    = 0;
            expAddr  = '0;
            expWdata = '0;
            expValid = 0;
            expMiss  = 0;
            p1Valid  = 0;
            p1Miss   = 0;
        end else begin
            expValid = p1Valid;
            expMiss  = p1Miss;
            expData  = p1Data;
            hasWork  = fifoQ.size() > 0;
            pushOk   = host_wr_valid && (fifoQ.size() < FIFO_DEPTH);
            if (hasWork && starve == STARVE_MAX) hostWins = 1;
            else if (blank)                      hostWins = hasWork;
            else                                 hostWins = hasWork && !disp_req;
            dispWins = disp_req && !hostWins;
            p1Valid  = dispWins;
            p1Miss   = disp_req && !dispWins;
            expEn    = hostWins || dispWins;
            expWe    = hostWins;
            if (hostWins) begin
                headEntry = fifoQ.pop_front();
                modelMem[headEntry.addr] = headEntry.data;
                expAddr  = headEntry.addr;
                expWdata = headEntry.data;
            end else if (dispWins) begin
                expAddr = disp_addr;
                p1Data  = modelMem[disp_addr];
            end
            if (hostWins || !hasWork) starve = 0;
            else if (starve < STARVE_MAX) starve = starve + 1;
            if (pushOk) fifoQ.push_back({host_addr, host_wdata});
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    // Four traffic regimes rotate so that streaming, blanking, starvation and backpressure all occur
    task automatic applyStimulus(input int cyc);
        int phase;
        phase = (cyc / 500) % 4;
        rstn  = !(cyc < 2 || $urandom_range(0, 299) == 0);
        disp_addr  = ADDR_W'($urandom_range(0, 31));
        host_addr  = ADDR_W'($urandom_range(0, 31));
        host_wdata = DATA_W'($urandom);
        case (phase)
            0: begin
                blank         = 1'b0;
                disp_req      = ($urandom_range(0, 9) != 0);
                host_wr_valid = ($urandom_range(0, 4) == 0);
            end
            1: begin
                blank         = ($urandom_range(0, 9) != 0);
                disp_req      = ($urandom_range(0, 9) < 7);
                host_wr_valid = ($urandom_range(0, 1) == 0);
            end
            2: begin
                blank         = 1'b0;
                disp_req      = 1'b1;
                host_wr_valid = ($urandom_range(0, 9) < 8);
            end
            default: begin
                if ($urandom_range(0, 15) == 0) blank = ~blank;
                disp_req      = $urandom_range(0, 1) == 1;
                host_wr_valid = $urandom_range(0, 1) == 1;
            end
        endcase
    endtask

    initial begin
        rstn          = 1'b0;
        blank         = 1'b0;
        disp_req      = 1'b0;
        disp_addr     = '0;
        host_wr_valid = 1'b0;
        host_addr     = '0;
        host_wdata    = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]      = DATA_W'($urandom);
            modelMem[i] = ram[i];
        end
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clkin);
            checkOutput("mem_en",     32'(mem_en),     32'(expEn));
            checkOutput("mem_we",     32'(mem_we),     32'(expWe));
            checkOutput("mem_addr",   32'(mem_addr),   32'(expAddr));
            checkOutput("mem_wdata",  32'(mem_wdata),  32'(expWdata));
            checkOutput("disp_valid", 32'(disp_valid), 32'(expValid));
            checkOutput("disp_miss",  32'(disp_miss),  32'(expMiss));
            if (expValid) checkOutput("disp_data", 32'(disp_data), 32'(expData));
            checkOutput("fifo_count", 32'(fifo_count), 32'(fifoQ.size()));
            checkOutput("host_wr_ready", 32'(host_wr_ready),
                        32'(rstn && (fifoQ.size() < FIFO_DEPTH)));
            applyStimulus(cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
